// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter: two writeback push channels, the RegFile write port and the scoreboard query.
// The master side drives requests and queries; the slave side is the arbiter itself.

interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          A_Valid;
    logic          A_Ready;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_Data;

    logic          M_Valid;
    logic          M_Ready;
    logic [AW-1:0] M_Addr;
    logic [DW-1:0] M_Data;

    logic          Reg_Write;
    logic [AW-1:0] Write_Reg_Addr;
    logic [DW-1:0] Write_Reg_Data;

    logic [AW-1:0] Query_Addr1;
    logic [AW-1:0] Query_Addr2;
    logic          Pending1;
    logic          Pending2;
    logic          Idle;

    modport master (
        output A_Valid, A_Addr, A_Data,
        output M_Valid, M_Addr, M_Data,
        output Query_Addr1, Query_Addr2,
        input  A_Ready, M_Ready,
        input  Reg_Write, Write_Reg_Addr, Write_Reg_Data,
        input  Pending1, Pending2, Idle
    );

    modport slave (
        input  A_Valid, A_Addr, A_Data,
        input  M_Valid, M_Addr, M_Data,
        input  Query_Addr1, Query_Addr2,
        output A_Ready, M_Ready,
        output Reg_Write, Write_Reg_Addr, Write_Reg_Data,
        output Pending1, Pending2, Idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU (A) and load (M) writebacks onto the single RegFile write port, plus a pending-write scoreboard.
// Optional feature macro RFWB_DROP_R0_EN: accept but discard writes to register 0 instead of queueing them.

module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic [AW-1:0] query1,
    input  logic [AW-1:0] query2,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          match1,
    output logic          match2
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;

    assign wr_idx    = wr_ptr[PW-1:0];
    assign rd_idx    = rd_ptr[PW-1:0];
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign empty     = (wr_ptr == rd_ptr);
    assign head_addr = addr_mem[rd_idx];
    assign head_data = data_mem[rd_idx];

    // slot_valid mirrors occupancy per slot so the scoreboard can ignore stale storage
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slot_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr             <= rd_ptr + PTR_ONE;
                slot_valid[rd_idx] <= 1'b0;
            end
            if (push) begin
                wr_ptr             <= wr_ptr + PTR_ONE;
                slot_valid[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= push_data;
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (addr_mem[i] == query1)) match1 = 1'b1;
            if (slot_valid[i] && (addr_mem[i] == query2)) match2 = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                 Clk,
    input  logic                 Clr,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_M = 1'b1
    } src_t;

    src_t          last_grant;
    logic          a_full, a_empty, a_push, a_pop, a_match1, a_match2;
    logic          m_full, m_empty, m_push, m_pop, m_match1, m_match2;
    logic [AW-1:0] a_head_addr, m_head_addr;
    logic [DW-1:0] a_head_data, m_head_data;
    logic          reg_write;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign bus.A_Ready = !a_full;
    assign bus.M_Ready = !m_full;

`ifdef RFWB_DROP_R0_EN
    assign a_push = bus.A_Valid && !a_full && (bus.A_Addr != '0);
    assign m_push = bus.M_Valid && !m_full && (bus.M_Addr != '0);
`else
    assign a_push = bus.A_Valid && !a_full;
    assign m_push = bus.M_Valid && !m_full;
`endif

    regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) a_fifo (
        .Clk       (Clk),
        .Clr       (Clr),
        .push      (a_push),
        .push_addr (bus.A_Addr),
        .push_data (bus.A_Data),
        .pop       (a_pop),
        .query1    (bus.Query_Addr1),
        .query2    (bus.Query_Addr2),
        .full      (a_full),
        .empty     (a_empty),
        .head_addr (a_head_addr),
        .head_data (a_head_data),
        .match1    (a_match1),
        .match2    (a_match2)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) m_fifo (
        .Clk       (Clk),
        .Clr       (Clr),
        .push      (m_push),
        .push_addr (bus.M_Addr),
        .push_data (bus.M_Data),
        .pop       (m_pop),
        .query1    (bus.Query_Addr1),
        .query2    (bus.Query_Addr2),
        .full      (m_full),
        .empty     (m_empty),
        .head_addr (m_head_addr),
        .head_data (m_head_data),
        .match1    (m_match1),
        .match2    (m_match2)
    );

    // A wins when alone or when M had the previous grant; otherwise M takes it
    always_comb begin
        a_pop = 1'b0;
        m_pop = 1'b0;
        if (!a_empty && (m_empty || (last_grant == SRC_M))) begin
            a_pop = 1'b1;
        end else if (!m_empty) begin
            m_pop = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            reg_write  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= SRC_M;
        end else begin
            reg_write <= a_pop || m_pop;
            if (a_pop) begin
                wr_addr    <= a_head_addr;
                wr_data    <= a_head_data;
                last_grant <= SRC_A;
            end else if (m_pop) begin
                wr_addr    <= m_head_addr;
                wr_data    <= m_head_data;
                last_grant <= SRC_M;
            end
        end
    end

    assign bus.Reg_Write      = reg_write;
    assign bus.Write_Reg_Addr = wr_addr;
    assign bus.Write_Reg_Data = wr_data;

    // Register 0 never reports pending, so the control FSM never stalls on it
    assign bus.Pending1 = (bus.Query_Addr1 != '0) &&
                          (a_match1 || m_match1 || (reg_write && (wr_addr == bus.Query_Addr1)));
    assign bus.Pending2 = (bus.Query_Addr2 != '0) &&
                          (a_match2 || m_match2 || (reg_write && (wr_addr == bus.Query_Addr2)));

    assign bus.Idle = a_empty && m_empty && !reg_write;
endmodule
